pwm_multichannel: RTL and testbench
===================================

# pwm_multichannel

Parametrised multi-channel PWM generator, successor to the single-channel fixed-speed PWM block used in the tile top level. It drives `CHANNELS` outputs from one shared period counter with a programmable prescaler. Each channel has a `WIDTH`-bit duty value, written through a valid/ready port into shadow registers that transfer glitch-free at the period boundary. It adds an optional center-aligned mode. It sits behind the top-level pin wrapper, which maps its ports onto `ui_in`/`uo_out`/`uio_*`.

## Interface
- `CHANNELS`, 4, number of PWM outputs (1..8)
- `WIDTH`, 8, duty/counter width; `MAX = 2**WIDTH - 1`
- `PRESCALE_WIDTH`, 8, prescaler reload width
- `clock`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  run/stop; low holds counters and forces outputs low
- `prescale`  in  PRESCALE_WIDTH  counter advances every `prescale+1` clocks
- `center_mode`  in  1  0 = edge-aligned, 1 = center-aligned
- `wr_valid`  in  1  duty write request
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`
- `wr_channel`  in  3  target channel index
- `wr_duty`  in  WIDTH  new duty value
- `pwm`  out  CHANNELS  registered PWM outputs
- `period_start`  out  1  one-clock pulse on every period boundary

## Operation
- Prescaler counts 0..`prescale`. `tick` = (prescaler == `prescale`) && `enable`. On `tick` the prescaler wraps to 0 and the period counter advances.
- Edge mode: counter runs 0..MAX-1, then wraps to 0. Period = MAX ticks. `pwm[i]` is high while `cnt < duty_active[i]`.
- Center mode: counter runs up 0..MAX-1, then down MAX-1..0. Both end values are held for two ticks across the turnaround. Period = 2·MAX ticks. `pwm[i]` is high while `cnt >= MAX - duty_active[i]`, giving a high time of 2·duty ticks centered in the period.
- In both modes, duty 0 gives constant low and duty MAX gives constant high. There is no glitch at the wrap.
- Period boundary: the tick on which the counter enters the period's first state (0 in edge mode, 0 at the start of the up phase in center mode).
- At each boundary:
  - all `duty_shadow` copy to `duty_active`;
  - `center_mode` and `prescale` are latched into their active registers;
  - `period_start` pulses.
- Mid-period changes on `center_mode`/`prescale`/writes are invisible until the next boundary.
- Writes: accepted on `wr_valid && wr_ready` and stored to `duty_shadow[wr_channel]`.
  - `wr_ready` is low only on the boundary-transfer clock, so no write ever races the copy.
  - `wr_channel >= CHANNELS` is accepted and discarded.
- `enable` low:
  - prescaler and counter are held at 0, direction is up, `pwm` = 0, no `period_start`;
  - shadows still accept writes;
  - active registers continuously track shadow/inputs.
- `enable` rising: the first tick starts a period immediately. `period_start` pulses and the latest shadows are used.
- `reset`: counters 0, direction up, all shadow and active duty 0, active mode edge, active prescale 0, `pwm` = 0, `period_start` = 0, `wr_ready` = 1 from the clock after reset deasserts. Reset mid-period aborts the period with no partial pulse.

## Timing
- `pwm` and `period_start` are registered. They reflect the counter value of the same clock edge that updated the counter, so output edges align to tick edges.
- Counter value is held for `prescale+1` clocks.
- Edge period = MAX·(`prescale`+1) clocks. Center period = 2·MAX·(`prescale`+1) clocks.
- Write-to-output latency: a write accepted in period N takes effect in period N+1. A write accepted on the clock before a boundary takes effect at that boundary.
- Back-to-back writes are sustained at one per clock except the boundary clock.
- Simultaneous writes to the same channel in consecutive cycles: last write wins.

## Structure
- Package `pwm_pkg`: channel-index width constant (3), `MAX` function of `WIDTH`, direction encoding (`DIR_UP`, `DIR_DOWN`).
- Sub-module `pwm_prescaler`: reload counter producing `tick`; inputs `clock`, `reset`, `enable`, `prescale`.
- The top module holds the period counter/direction FSM, shadow/active register arrays and per-channel comparators in a generate loop.

## Test plan
All scenarios use `WIDTH=4` (MAX=15), `CHANNELS=4`, `prescale=0` unless stated.
- Edge mode, duties {0,5,15,7}: per 15-clock period, ch0 always low, ch1 high 5 clocks starting at `period_start`, ch2 always high, ch3 high 7 clocks. `period_start` fires every 15 clocks.
- `prescale=2`, duty 5: period 45 clocks, high 15 clocks.
- Write ch1=9 at clock 4 of a period: the current period stays at 5 high; the next period starts with 9 high. Write on the boundary clock sees `wr_ready=0` and is retried one clock later.
- Center mode, duty 3: period 30 clocks, high 6 clocks centered (clocks 12–17 of the period). Toggling `center_mode` mid-period switches only at the next `period_start`.
- `wr_channel=6` write: no channel changes. `enable` low mid-period: `pwm`=0 next clock, counter held at 0. `enable` high again: `period_start` on the first tick.
- Assert `reset` mid-pulse: `pwm`=0 the following clock, all duties read back as 0 (all outputs stay low after re-enable).

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants, direction encoding and full-scale helper for the PWM block
package pwm_pkg;
   localparam int CH_W = 3;
   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
   function automatic int unsigned pwm_max(int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction
endpackage

// File: rtl/pwm_if.sv
// pwm_if: valid/ready duty-write port
interface pwm_if #(parameter int WIDTH = 8);
   import pwm_pkg::*;
   logic wr_valid;
   logic wr_ready;
   logic [CH_W-1:0] wr_channel;
   logic [WIDTH-1:0] wr_duty;
   modport master (output wr_valid, wr_channel, wr_duty, input wr_ready);
   modport slave (input wr_valid, wr_channel, wr_duty, output wr_ready);
endinterface

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: reload counter giving one tick every prescale+1 enabled clocks
module pwm_prescaler #(
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic tick
);
   logic [PRESCALE_WIDTH-1:0] count;
   assign tick = enable && count == prescale;
   always_ff @(posedge clock)
      count <= (reset || !enable || tick) ? '0 : count + PRESCALE_WIDTH'(1);
endmodule

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: CHANNELS PWM outputs off one shared, prescaled period counter
// with shadowed duty writes and optional center-aligned counting
module pwm_multichannel
   import pwm_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH = 8,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic center_mode,
   pwm_if.slave wr,
   output logic [CHANNELS-1:0] pwm,
   output logic period_start
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(pwm_max(WIDTH));
   localparam logic [WIDTH-1:0] LAST = MAX - WIDTH'(1);
   logic tick, boundary, load, fresh, rst_done, mode_act, mode_nxt, wr_fire;
   logic [PRESCALE_WIDTH-1:0] psc_act, psc_nxt;
   logic [WIDTH-1:0] cnt, cnt_nxt;
   dir_t dir, dir_nxt;
   logic [CHANNELS-1:0] pwm_nxt;

   pwm_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_prescaler (
      .clock(clock), .reset(reset), .enable(enable), .prescale(psc_act), .tick(tick)
   );

   // fresh marks "no period running yet", so the first tick after reset/enable is a boundary
   always_ff @(posedge clock)
      if (reset || !enable) begin
         cnt <= '0;
         dir <= DIR_UP;
         fresh <= 1'b1;
      end else if (tick) begin
         cnt <= cnt_nxt;
         dir <= dir_nxt;
         fresh <= 1'b0;
      end

   // center mode holds each end value for two ticks by turning around without stepping
   always_comb begin
      boundary = tick && (fresh || (mode_act ? (dir == DIR_DOWN && cnt == '0) : (cnt == LAST)));
      cnt_nxt = cnt;
      dir_nxt = dir;
      if (boundary) begin
         cnt_nxt = '0;
         dir_nxt = DIR_UP;
      end else if (tick && mode_act && dir == DIR_UP && cnt == LAST)
         dir_nxt = DIR_DOWN;
      else if (tick)
         cnt_nxt = dir == DIR_UP ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
   end

   always_comb begin
      load = boundary || !enable;
      mode_nxt = load ? center_mode : mode_act;
      psc_nxt = load ? prescale : psc_act;
      wr_fire = wr.wr_valid && wr.wr_ready;
   end

   assign wr.wr_ready = rst_done && !boundary;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [WIDTH-1:0] shadow, active, duty;
      assign duty = load ? shadow : active;
      assign pwm_nxt[c] = mode_nxt ? cnt_nxt >= MAX - duty : cnt_nxt < duty;
      always_ff @(posedge clock)
         if (reset) begin
            shadow <= '0;
            active <= '0;
         end else begin
            if (wr_fire && wr.wr_channel == CH_W'(c)) shadow <= wr.wr_duty;
            active <= duty;
         end
   end

   always_ff @(posedge clock)
      if (reset) begin
         pwm <= '0;
         period_start <= 1'b0;
         mode_act <= 1'b0;
         psc_act <= '0;
         rst_done <= 1'b0;
      end else begin
         pwm <= !enable ? '0 : tick ? pwm_nxt : pwm;
         period_start <= boundary;
         mode_act <= mode_nxt;
         psc_act <= psc_nxt;
         rst_done <= 1'b1;
      end
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: segment table plus per-clock scoreboard for pwm_multichannel
module tb_pwm_multichannel;
   localparam int CH = 4, W = 4, PW = 8, MX = 15;
   logic clock = 1'b0, reset = 1'b1, enable = 1'b0, center_mode = 1'b0;
   logic [PW-1:0] prescale = '0;
   logic [CH-1:0] pwm;
   logic period_start;
   pwm_if #(.WIDTH(W)) wr ();

   pwm_multichannel #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
      .clock(clock), .reset(reset), .enable(enable), .prescale(prescale),
      .center_mode(center_mode), .wr(wr), .pwm(pwm), .period_start(period_start)
   );

   always #5 clock = ~clock;

   typedef struct packed {logic [CH-1:0] pwm; logic ps;} exp_t;
   typedef struct {bit mode; int psc; int duty[CH]; int hi[CH];} seg_t;
   exp_t q[$];
   int passed = 0, total = 0;
   int hi_cnt[CH], ps_cnt;
   bit last_rdy;
   // reference: position (in clocks) inside the running period, independent of counter direction
   bit m_run, m_rstd, m_mode;
   int m_t, m_wait, m_psc;
   int m_duty[CH], m_sh[CH];

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
   endtask

   function automatic bit pred_bnd();
      int l = (m_mode ? 2 : 1) * MX * (m_psc + 1);
      if (reset || !enable) return 1'b0;
      return m_run ? (m_t == l - 1) : (m_wait == m_psc);
   endfunction

   task automatic model_edge();
      exp_t e = '0;
      bit b = pred_bnd();
      bit fire = wr.wr_valid && m_rstd && !b && !reset;
      if (reset) begin
         m_run = 0; m_wait = 0; m_mode = 0; m_psc = 0; m_rstd = 0;
         for (int i = 0; i < CH; i++) begin
            m_duty[i] = 0;
            m_sh[i] = 0;
         end
      end else begin
         m_rstd = 1;
         if (!enable) begin
            m_run = 0; m_wait = 0; m_mode = center_mode; m_psc = int'(prescale); m_duty = m_sh;
         end else if (b) begin
            m_mode = center_mode; m_psc = int'(prescale); m_duty = m_sh; m_run = 1; m_t = 0;
         end else if (m_run) m_t++;
         else m_wait++;
         if (fire && int'(wr.wr_channel) < CH) m_sh[wr.wr_channel] = int'(wr.wr_duty);
         if (enable && m_run) begin
            int k = m_t / (m_psc + 1);
            for (int i = 0; i < CH; i++)
               e.pwm[i] = m_mode ? (k >= MX - m_duty[i] && k < MX + m_duty[i]) : (k < m_duty[i]);
            e.ps = b;
         end
      end
      q.push_back(e);
   endtask

   task automatic cycle();
      exp_t e;
      #1;
      last_rdy = wr.wr_ready;
      if (!reset) chk("wr_ready", int'(wr.wr_ready), int'(m_rstd && !pred_bnd()));
      model_edge();
      @(posedge clock);
      #1;
      e = q.pop_front();
      chk("pwm", int'(pwm), int'(e.pwm));
      chk("period_start", int'(period_start), int'(e.ps));
      for (int i = 0; i < CH; i++) hi_cnt[i] += int'(pwm[i]);
      ps_cnt += int'(period_start);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic clr();
      for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
      ps_cnt = 0;
   endtask

   task automatic write(input int ch, input int d, output int tries);
      wr.wr_valid = 1'b1;
      wr.wr_channel = 3'(ch);
      wr.wr_duty = 4'(d);
      tries = 0;
      do begin
         cycle();
         tries++;
      end while (!last_rdy && tries < 4);
      wr.wr_valid = 1'b0;
      chk("write_accept", int'(last_rdy), 1);
   endtask

   initial begin
      seg_t seg[4];
      int tries, l;
      seg[0] = '{mode: 1'b0, psc: 0, duty: '{0, 5, 15, 7}, hi: '{0, 10, 30, 14}};
      seg[1] = '{mode: 1'b0, psc: 2, duty: '{5, 0, 1, 14}, hi: '{30, 0, 6, 84}};
      seg[2] = '{mode: 1'b1, psc: 0, duty: '{3, 15, 0, 8}, hi: '{12, 60, 0, 32}};
      seg[3] = '{mode: 1'b1, psc: 1, duty: '{1, 7, 14, 15}, hi: '{8, 56, 112, 120}};
      wr.wr_valid = 1'b0;
      wr.wr_channel = '0;
      wr.wr_duty = '0;
      run(2);
      reset = 1'b0;
      run(2);
      // each segment: program while stopped, then two full periods after the first tick
      for (int s = 0; s < 4; s++) begin
         enable = 1'b0;
         center_mode = seg[s].mode;
         prescale = PW'(seg[s].psc);
         cycle();
         for (int c = 0; c < CH; c++) write(c, seg[s].duty[c], tries);
         enable = 1'b1;
         l = (seg[s].mode ? 2 : 1) * MX * (seg[s].psc + 1);
         clr();
         run(seg[s].psc + 2 * l);
         for (int c = 0; c < CH; c++) chk($sformatf("seg%0d_high_ch%0d", s, c), hi_cnt[c], seg[s].hi[c]);
         chk($sformatf("seg%0d_period_starts", s), ps_cnt, 2);
      end
      // mid-period write lands next period; boundary write is refused once
      enable = 1'b0;
      center_mode = 1'b0;
      prescale = '0;
      cycle();
      for (int c = 0; c < CH; c++) write(c, c == 1 ? 5 : 0, tries);
      enable = 1'b1;
      clr();
      run(4);
      write(1, 9, tries);
      run(10);
      chk("midwrite_old_duty", hi_cnt[1], 5);
      clr();
      run(15);
      chk("midwrite_new_duty", hi_cnt[1], 9);
      chk("midwrite_period_start", ps_cnt, 1);
      write(1, 2, tries);
      chk("boundary_retry", tries, 2);
      run(13);
      clr();
      run(15);
      chk("retry_duty", hi_cnt[1], 2);
      // mode change is deferred to the next boundary
      run(5);
      center_mode = 1'b1;
      clr();
      run(10);
      chk("mode_hold_high", hi_cnt[1], 0);
      chk("mode_hold_ps", ps_cnt, 0);
      clr();
      run(30);
      chk("center_high", hi_cnt[1], 4);
      chk("center_ps", ps_cnt, 1);
      // out-of-range channel discarded, consecutive writes last-wins
      write(6, 11, tries);
      write(2, 3, tries);
      write(2, 6, tries);
      run(30);
      clr();
      run(30);
      for (int c = 0; c < CH; c++) chk($sformatf("chan_high_ch%0d", c), hi_cnt[c], c == 1 ? 4 : c == 2 ? 12 : 0);
      // enable drop and restart
      run(7);
      enable = 1'b0;
      cycle();
      chk("disable_pwm", int'(pwm), 0);
      run(3);
      enable = 1'b1;
      cycle();
      chk("reenable_ps", int'(period_start), 1);
      // reset while outputs are high
      write(0, 15, tries);
      run(31);
      chk("pre_reset_ch0", int'(pwm[0]), 1);
      reset = 1'b1;
      cycle();
      chk("reset_pwm", int'(pwm), 0);
      reset = 1'b0;
      cycle();
      clr();
      run(30);
      for (int c = 0; c < CH; c++) chk($sformatf("post_reset_ch%0d", c), hi_cnt[c], 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
